// File: rtl/msx_mux_scanner.sv
// msx_mux_scanner: round-robin scanner for the multiplexed cartridge-edge input
// buffers. It drives one active-low enable per 8-bit group and waits SETTLE
// cycles after each switch. Each sampled bit is deglitched by an N-sample
// agreement filter. Results are published both as a live view and as a
// frame-coherent snapshot with a strobe and a change flag.
module msx_mux_scanner #(
    parameter int GROUPS       = 3,
    parameter int SETTLE       = 1,
    parameter int SAMPLES      = 2,
    parameter int FILTER_DEPTH = 2,
    parameter logic [GROUPS*8-1:0] RESET_VALUE = '1
) (
    input  logic                  CLK,
    input  logic                  RESET_n,
    input  logic [7:0]            MUX_SIG,
    input  logic [GROUPS-1:0]     GROUP_EN,
    output logic [GROUPS-1:0]     MUX_CS_n,
    output logic [GROUPS*8-1:0]   LIVE,
    output logic [GROUPS*8-1:0]   FRAME,
    output logic                  FRAME_STB,
    output logic                  CHANGED
);

    localparam int SLOT = SETTLE + SAMPLES;
    localparam int CW   = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int GW   = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int NB   = GROUPS * 8;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                                  state_q, state_d;
    logic [CW-1:0]                           cnt_q, cnt_d;
    logic [GW-1:0]                           grp_q, grp_d;
    logic [GROUPS-1:0]                       en_q, en_d;
    logic [GROUPS-1:0]                       cs_n_q, cs_n_d;
    logic [NB-1:0][FILTER_DEPTH-1:0]         hist_q, hist_d;
    logic [NB-1:0]                           filt_q, filt_d;
    logic [NB-1:0]                           frame_q, frame_d;
    logic                                    stb_q, stb_d;
    logic                                    chg_q, chg_d;

    logic          nxt_found;
    logic [GW-1:0] nxt_grp;
    logic [GW-1:0] first_grp;
    logic          slot_end;
    logic          sample_en;
    logic          frame_close;
    logic          frame_start;

    // Schedule lookups: next enabled group above the current one (from the
    // latched mask) and the lowest group requested for the coming frame.
    always_comb begin
        nxt_found = 1'b0;
        nxt_grp   = '0;
        first_grp = '0;
        for (int i = GROUPS - 1; i >= 0; i--) begin
            if (en_q[i] && (i > int'(grp_q))) begin
                nxt_found = 1'b1;
                nxt_grp   = GW'(i);
            end
            if (GROUP_EN[i]) first_grp = GW'(i);
        end
        slot_end    = (int'(cnt_q) == SLOT - 1);
        sample_en   = (state_q == SCAN) && (int'(cnt_q) >= SETTLE);
        frame_close = (state_q == SCAN) && slot_end && !nxt_found;
        // An idle scanner re-evaluates the mask every cycle; a scanning one
        // only at the edge closing the last slot, so frames run back to back.
        frame_start = (state_q == IDLE) || frame_close;
    end

    // Next-state: slot counter, group walk, CS pattern, filters and snapshot.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grp_d   = grp_q;
        en_d    = en_q;
        cs_n_d  = cs_n_q;
        hist_d  = hist_q;
        filt_d  = filt_q;
        frame_d = frame_q;
        stb_d   = 1'b0;
        chg_d   = 1'b0;

        if (state_q == SCAN) begin
            cnt_d = slot_end ? '0 : cnt_q + 1'b1;
            if (slot_end && nxt_found) begin
                grp_d  = nxt_grp;
                cs_n_d = ~(GROUPS'(1) << nxt_grp);
            end
        end

        if (frame_start) begin
            en_d  = GROUP_EN;
            cnt_d = '0;
            if (GROUP_EN != '0) begin
                state_d = SCAN;
                grp_d   = first_grp;
                cs_n_d  = ~(GROUPS'(1) << first_grp);
            end else begin
                state_d = IDLE;
                cs_n_d  = '1;
            end
        end

        // Only the active group's bits shift; the new sample enters the
        // history directly, and the output follows only on full agreement.
        for (int b = 0; b < NB; b++) begin
            if (sample_en && ((b >> 3) == int'(grp_q))) begin
                hist_d[b] = (hist_q[b] << 1) | FILTER_DEPTH'(MUX_SIG[b[2:0]]);
                if ((hist_d[b] == '0) || (hist_d[b] == '1))
                    filt_d[b] = MUX_SIG[b[2:0]];
            end
        end

        // Snapshot includes the sample taken on the closing edge itself.
        if (frame_close) begin
            frame_d = filt_d;
            stb_d   = 1'b1;
            chg_d   = (filt_d != frame_q);
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grp_q   <= '0;
            en_q    <= '0;
            cs_n_q  <= '1;
            for (int b = 0; b < NB; b++)
                hist_q[b] <= {FILTER_DEPTH{RESET_VALUE[b]}};
            filt_q  <= RESET_VALUE;
            frame_q <= RESET_VALUE;
            stb_q   <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grp_q   <= grp_d;
            en_q    <= en_d;
            cs_n_q  <= cs_n_d;
            hist_q  <= hist_d;
            filt_q  <= filt_d;
            frame_q <= frame_d;
            stb_q   <= stb_d;
            chg_q   <= chg_d;
        end
    end

    assign MUX_CS_n  = cs_n_q;
    assign LIVE      = filt_q;
    assign FRAME     = frame_q;
    assign FRAME_STB = stb_q;
    assign CHANGED   = chg_q;

endmodule

// File: tb/tb_msx_mux_scanner.sv
// Testbench for msx_mux_scanner. A board model drives the shared pins from
// whichever buffer is enabled; garbage is driven while idle or settling. A
// frame-level reference model predicts CS, LIVE and FRAME each cycle, and
// queues each expected snapshot for the strobe monitor. A second instance
// covers a non-default parameter set with static pins.
module tb_msx_mux_scanner;

    localparam int G    = 3;
    localparam int SET  = 1;
    localparam int SAM  = 2;
    localparam int FD   = 2;
    localparam int SLOT = SET + SAM;
    localparam int NB   = G * 8;

    logic          CLK = 1'b0;
    logic          RESET_n = 1'b0;
    logic [7:0]    MUX_SIG = 8'h00;
    logic [G-1:0]  GROUP_EN = '0;
    logic [G-1:0]  MUX_CS_n;
    logic [NB-1:0] LIVE, FRAME;
    logic          FRAME_STB, CHANGED;

    logic [7:0]    MUX_SIG2 = 8'h5A;
    logic [3:0]    GROUP_EN2 = 4'hF;
    logic [3:0]    MUX_CS_n2;
    logic [31:0]   LIVE2, FRAME2;
    logic          FRAME_STB2, CHANGED2;

    msx_mux_scanner dut (
        .CLK(CLK), .RESET_n(RESET_n), .MUX_SIG(MUX_SIG), .GROUP_EN(GROUP_EN),
        .MUX_CS_n(MUX_CS_n), .LIVE(LIVE), .FRAME(FRAME),
        .FRAME_STB(FRAME_STB), .CHANGED(CHANGED)
    );

    msx_mux_scanner #(.GROUPS(4), .SETTLE(2), .SAMPLES(1), .FILTER_DEPTH(3)) dut2 (
        .CLK(CLK), .RESET_n(RESET_n), .MUX_SIG(MUX_SIG2), .GROUP_EN(GROUP_EN2),
        .MUX_CS_n(MUX_CS_n2), .LIVE(LIVE2), .FRAME(FRAME2),
        .FRAME_STB(FRAME_STB2), .CHANGED(CHANGED2)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- board model ----------------
    logic [7:0]   grp_data [G];
    logic [7:0]   glitch   [G];
    logic [G-1:0] prev_cs = '1;
    int           since = 0;

    // Pins follow the enabled buffer; garbage while idle or inside settle.
    always @(negedge CLK) begin
        int sel;
        #1;
        if (MUX_CS_n != prev_cs) since = 0;
        else if (since < 1000) since++;
        prev_cs = MUX_CS_n;
        sel = -1;
        for (int g = 0; g < G; g++) if (!MUX_CS_n[g]) sel = g;
        if (sel < 0 || since < SET) MUX_SIG = 8'($urandom);
        else MUX_SIG = grp_data[sel] ^ glitch[sel];
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [NB-1:0] frame;
        logic          chg;
    } exp_t;

    exp_t          sbq[$];
    bit            m_scan;
    int            m_list[$];
    int            m_pos;
    logic [NB-1:0] m_live, m_frame;
    bit            m_hist[NB][$];

    function automatic logic [G-1:0] exp_cs();
        logic [G-1:0] v;
        v = '1;
        if (m_scan) v[m_list[m_pos / SLOT]] = 1'b0;
        return v;
    endfunction

    task automatic m_frame_start();
        m_list.delete();
        for (int g = 0; g < G; g++) if (GROUP_EN[g]) m_list.push_back(g);
        m_pos  = 0;
        m_scan = (m_list.size() > 0);
    endtask

    always @(posedge CLK or negedge RESET_n) begin
        int   g, c, b;
        bit   same;
        exp_t e;
        if (!RESET_n) begin
            m_scan = 0;
            m_pos  = 0;
            m_list.delete();
            m_live  = '1;
            m_frame = '1;
            for (int i = 0; i < NB; i++) begin
                m_hist[i].delete();
                for (int k = 0; k < FD; k++) m_hist[i].push_back(1'b1);
            end
            sbq.delete();
        end else if (!m_scan) begin
            m_frame_start();
        end else begin
            g = m_list[m_pos / SLOT];
            c = m_pos % SLOT;
            if (c >= SET) begin
                for (int k = 0; k < 8; k++) begin
                    b = g * 8 + k;
                    m_hist[b].push_front(MUX_SIG[k]);
                    if (m_hist[b].size() > FD) void'(m_hist[b].pop_back());
                    same = 1;
                    foreach (m_hist[b][j]) if (m_hist[b][j] != m_hist[b][0]) same = 0;
                    if (same) m_live[b] = MUX_SIG[k];
                end
            end
            m_pos++;
            if (m_pos == m_list.size() * SLOT) begin
                e.frame = m_live;
                e.chg   = (m_live != m_frame);
                sbq.push_back(e);
                m_frame = m_live;
                m_frame_start();
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge CLK) begin
        exp_t e;
        bit   exp_stb;
        if (RESET_n) begin
            check("cs", MUX_CS_n, exp_cs());
            check("live", LIVE, m_live);
            exp_stb = (sbq.size() > 0);
            e.frame = m_frame;
            e.chg   = 1'b0;
            if (exp_stb) e = sbq.pop_front();
            check("frame_stb", FRAME_STB, exp_stb);
            check("changed", CHANGED, e.chg);
            check("frame", FRAME, e.frame);
        end
    end

    // ---------------- second instance: GROUPS=4 SETTLE=2 SAMPLES=1 DEPTH=3 ----------------
    int n2 = 0;
    int t2 = 0;
    int last2 = 0;

    always @(negedge RESET_n) begin
        n2 = 0;
        t2 = 0;
        last2 = 0;
    end

    always @(negedge CLK) begin
        if (RESET_n && n2 < 4) begin
            t2++;
            if (FRAME_STB2) begin
                n2++;
                if (n2 > 1) check("p2_frame_len", t2 - last2, 12);
                last2 = t2;
                if (n2 < 3) begin
                    check("p2_frame_early", FRAME2, 32'hFFFF_FFFF);
                    check("p2_changed_early", CHANGED2, 0);
                end else begin
                    check("p2_frame", FRAME2, 32'h5A5A_5A5A);
                    check("p2_live", LIVE2, 32'h5A5A_5A5A);
                    check("p2_changed", CHANGED2, (n2 == 3) ? 1 : 0);
                end
            end else begin
                check("p2_stb_idle", CHANGED2, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_cs(input logic [G-1:0] target);
        int k;
        k = 0;
        while (MUX_CS_n !== target && k < 50) begin
            @(negedge CLK);
            k++;
        end
        if (k >= 50) check("wait_cs_timeout", MUX_CS_n, target);
    endtask

    initial begin
        int r;
        for (int g = 0; g < G; g++) begin
            grp_data[g] = 8'hFF;
            glitch[g]   = 8'h00;
        end
        GROUP_EN = 3'b111;
        RESET_n  = 1'b0;
        cycles(3);
        check("rst_cs", MUX_CS_n, 3'b111);
        check("rst_live", LIVE, 24'hFFFFFF);
        check("rst_frame", FRAME, 24'hFFFFFF);
        check("rst_stb", FRAME_STB, 0);
        check("rst_changed", CHANGED, 0);

        // static data
        grp_data[0] = 8'hA5;
        grp_data[1] = 8'h3C;
        grp_data[2] = 8'h0F;
        RESET_n = 1'b1;
        @(negedge CLK);
        check("first_cs", MUX_CS_n, 3'b110);
        cycles(40);
        check("static_frame", FRAME, 24'h0F3CA5);

        // one-sample glitch on group1 bit0
        wait_cs(3'b101);
        @(negedge CLK);
        glitch[1] = 8'h01;
        @(negedge CLK);
        glitch[1] = 8'h00;
        cycles(20);
        check("glitch_live", LIVE[15:8], 8'h3C);
        check("glitch_frame", FRAME[15:8], 8'h3C);

        // mask change inside group0's slot; group1 pins then change
        wait_cs(3'b110);
        GROUP_EN = 3'b101;
        cycles(12);
        grp_data[1] = 8'hC3;
        cycles(24);
        check("masked_live", LIVE[15:8], 8'h3C);

        // all groups off, then only group1
        GROUP_EN = 3'b000;
        cycles(20);
        check("idle_cs", MUX_CS_n, 3'b111);
        GROUP_EN = 3'b010;
        @(negedge CLK);
        check("reenable_cs", MUX_CS_n, 3'b101);
        cycles(20);
        check("reenable_live", LIVE[15:8], 8'hC3);

        // asynchronous reset in the middle of a slot
        GROUP_EN = 3'b111;
        cycles(7);
        @(posedge CLK);
        #2 RESET_n = 1'b0;
        #1;
        check("midrst_cs", MUX_CS_n, 3'b111);
        check("midrst_live", LIVE, 24'hFFFFFF);
        check("midrst_stb", FRAME_STB, 0);
        @(negedge CLK);
        RESET_n = 1'b1;
        cycles(60);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            for (int g = 0; g < G; g++) glitch[g] = 8'h00;
            r = $urandom_range(0, 99);
            if (r < 5) grp_data[$urandom_range(0, G - 1)] = 8'($urandom);
            else if (r < 8) GROUP_EN = ($urandom_range(0, 5) == 0) ? 3'b000 : 3'($urandom);
            else if (r < 15) glitch[$urandom_range(0, G - 1)] = 8'($urandom);
            @(negedge CLK);
        end
        for (int g = 0; g < G; g++) glitch[g] = 8'h00;
        cycles(40);
        check("p2_strobes_seen", (n2 >= 4) ? 1 : 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
